// File: rtl/car_pkg.sv
// Shared encodings for the vehicle drive controller: car state, drive mode,
// moving direction and the power sequencing FSM.
package car_pkg;

    typedef enum logic [1:0] {
        NSTART  = 2'b00,
        START   = 2'b01,
        MOVING  = 2'b10,
        ST_RSVD = 2'b11
    } car_state_e;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SEMI   = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        P_OFF = 2'b00,
        P_ARM = 2'b01,
        P_REL = 2'b10,
        P_ON  = 2'b11
    } pwr_state_e;

    localparam logic [3:0] MV_NONE  = 4'b0000;
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_BACK  = 4'b0010;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

endpackage

// File: rtl/hold_counter.sv
// Cycle counter with synchronous clear; done fires on the enabled cycle in
// which the count reaches TC-1 (TC must be at least 2).
module hold_counter #(
    parameter int unsigned TC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam int W = (TC > 2) ? $clog2(TC) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // done looks at the value being counted into, so it lines up with the edge
    assign done = en && !clr && (cnt == W'(TC - 2));

endmodule

// File: rtl/drive_arbiter.sv
// Power sequencing and mode arbitration for the drive controller: selects one
// of three request lanes (manual/semi/auto) and gates it behind power state.
//
// state | meaning
// P_OFF | vehicle unpowered, waiting for power button
// P_ARM | button held, counting towards power-on
// P_REL | powered, waiting for the power-on press to be released
// P_ON  | powered; button, lane power request or idle timeout turn it off
module drive_arbiter
    import car_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned IDLE_CYCLES = 1000000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_btn,
    input  logic [1:0]  mode_sel,
    input  logic [5:0]  req_state,
    input  logic [11:0] req_moving,
    input  logic [2:0]  req_power,
    output logic        power,
    output logic [1:0]  global_state,
    output logic [1:0]  state,
    output logic [3:0]  moving_state,
    output logic        mode_reject
);

    pwr_state_e pstate, pstate_nx;

    logic       hold_en, hold_clr, hold_done;
    logic       idle_en, idle_clr, idle_done;
    logic       power_off;
    logic [1:0] lane_state;
    logic [3:0] lane_moving;
    logic       lane_keep;
    logic       mode_ok;
    logic [1:0] mode_sel_q;

    always_comb begin
        lane_state  = req_state[1:0];
        lane_moving = req_moving[3:0];
        lane_keep   = req_power[0];
        case (global_state)
            MODE_SEMI: begin
                lane_state  = req_state[3:2];
                lane_moving = req_moving[7:4];
                lane_keep   = req_power[1];
            end
            MODE_AUTO: begin
                lane_state  = req_state[5:4];
                lane_moving = req_moving[11:8];
                lane_keep   = req_power[2];
            end
            default: ;
        endcase
    end

    assign hold_en  = (pstate == P_ARM) && power_btn;
    assign hold_clr = !hold_en;
    assign idle_en  = (pstate == P_ON) && (state == NSTART) && !power_btn;
    assign idle_clr = !idle_en;

    hold_counter #(.TC(HOLD_CYCLES)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .en   (hold_en),
        .clr  (hold_clr),
        .done (hold_done)
    );

    hold_counter #(.TC(IDLE_CYCLES)) u_idle (
        .clk  (clk),
        .rst  (rst),
        .en   (idle_en),
        .clr  (idle_clr),
        .done (idle_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pstate <= P_OFF;
        else      pstate <= pstate_nx;
    end

    always_comb begin
        pstate_nx = pstate;
        power_off = 1'b0;
        unique case (pstate)
            P_OFF: if (power_btn) pstate_nx = P_ARM;
            P_ARM: begin
                if (!power_btn)     pstate_nx = P_OFF;
                else if (hold_done) pstate_nx = P_REL;
            end
            P_REL: if (!power_btn) pstate_nx = P_ON;
            P_ON: begin
                if (power_btn || !lane_keep || idle_done) begin
                    power_off = 1'b1;
                    pstate_nx = P_OFF;
                end
            end
            default: pstate_nx = P_OFF;
        endcase
    end

    assign power   = (pstate == P_REL) || (pstate == P_ON);
    // acceptance uses the registered state, not the lane request
    assign mode_ok = (state == NSTART) && (mode_sel != MODE_RSVD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            global_state <= MODE_MANUAL;
            state        <= NSTART;
            moving_state <= MV_NONE;
            mode_reject  <= 1'b0;
            mode_sel_q   <= MODE_MANUAL;
        end else begin
            mode_sel_q  <= mode_sel;
            mode_reject <= 1'b0;
            if (!power || power_off) begin
                global_state <= MODE_MANUAL;
                state        <= NSTART;
                moving_state <= MV_NONE;
            end else begin
                if (lane_state == ST_RSVD) begin
                    state        <= NSTART;
                    moving_state <= MV_NONE;
                end else begin
                    state        <= lane_state;
                    moving_state <= lane_moving;
                end
                if (mode_ok)
                    global_state <= mode_sel;
                else if (mode_sel != mode_sel_q)
                    mode_reject <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with short hold (4) and idle (8) times.
module tb_drive_arbiter;

    logic        clk;
    logic        rst;
    logic        power_btn;
    logic [1:0]  mode_sel;
    logic [5:0]  req_state;
    logic [11:0] req_moving;
    logic [2:0]  req_power;
    logic        power;
    logic [1:0]  global_state;
    logic [1:0]  state;
    logic [3:0]  moving_state;
    logic        mode_reject;

    int checks = 0;
    int errors = 0;

    drive_arbiter #(.HOLD_CYCLES(4), .IDLE_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .power_btn    (power_btn),
        .mode_sel     (mode_sel),
        .req_state    (req_state),
        .req_moving   (req_moving),
        .req_power    (req_power),
        .power        (power),
        .global_state (global_state),
        .state        (state),
        .moving_state (moving_state),
        .mode_reject  (mode_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst        = 1'b0;
        power_btn  = 1'b0;
        mode_sel   = 2'b00;
        req_state  = 6'b00_00_00;
        req_moving = 12'h000;
        req_power  = 3'b111;
        step(2);
        chk("rst_power", power, 0);
        chk("rst_global", global_state, 0);
        chk("rst_state", state, 0);
        chk("rst_moving", moving_state, 0);
        chk("rst_reject", mode_reject, 0);
        rst = 1'b1;
        step(1);

        // 3-cycle hold must not power on
        power_btn = 1'b1;
        step(3);
        chk("hold3_pwr", power, 0);
        power_btn = 1'b0;
        step(1);
        chk("hold3_rel", power, 0);
        step(1);

        // 4-cycle hold powers on; still in P_REL while held
        power_btn = 1'b1;
        step(3);
        chk("hold4_c3", power, 0);
        step(1);
        chk("hold4_c4", power, 1);
        // lanes: auto=10/1000, semi=11/0100, manual=01/0000
        req_state  = 6'b10_11_01;
        req_moving = 12'b1000_0100_0000;
        step(1);
        chk("rel_held_pwr", power, 1);
        chk("man_state01", state, 2'b01);
        chk("man_mov0", moving_state, 4'b0000);
        req_state  = 6'b10_11_10;
        req_moving = 12'b1000_0100_0001;
        power_btn  = 1'b0;
        step(1);
        chk("on_pwr", power, 1);
        chk("man_state10", state, 2'b10);
        chk("man_mov1", moving_state, 4'b0001);

        // mode change refused while moving
        mode_sel = 2'b10;
        step(1);
        chk("rej_pulse", mode_reject, 1);
        chk("rej_global", global_state, 2'b00);
        step(1);
        chk("rej_once", mode_reject, 0);
        chk("rej_hold", global_state, 2'b00);
        req_state  = 6'b10_11_00;
        req_moving = 12'b1000_0100_0000;
        step(1);
        chk("man_nstart", state, 2'b00);
        mode_sel = 2'b00;
        step(1);
        chk("acc_no_rej", mode_reject, 0);
        mode_sel = 2'b10;
        step(1);
        chk("acc_global", global_state, 2'b10);
        chk("acc_no_rej2", mode_reject, 0);
        step(1);
        chk("auto_state", state, 2'b10);
        chk("auto_mov", moving_state, 4'b1000);

        // active (auto) lane drops its power request
        req_power = 3'b011;
        step(1);
        chk("rpo_power", power, 0);
        chk("rpo_state", state, 0);
        chk("rpo_moving", moving_state, 0);
        chk("rpo_global", global_state, 0);
        req_power = 3'b111;
        mode_sel  = 2'b00;
        step(1);

        // idle timeout: 7 enabled cycles in P_ON at NSTART
        power_btn = 1'b1;
        step(4);
        chk("idle_pwron", power, 1);
        power_btn = 1'b0;
        step(1);
        step(6);
        chk("idle_pre", power, 1);
        step(1);
        chk("idle_off", power, 0);
        chk("idle_state", state, 0);
        chk("idle_moving", moving_state, 0);
        chk("idle_global", global_state, 0);
        step(1);

        // reset mid-hold discards progress
        power_btn = 1'b1;
        step(3);
        rst = 1'b0;
        #1;
        chk("rstmid_pwr", power, 0);
        step(1);
        rst = 1'b1;
        step(2);
        chk("rstmid_after", power, 0);
        step(2);
        chk("rstmid_rehold", power, 1);
        power_btn = 1'b0;
        step(1);
        chk("btn_on", power, 1);
        power_btn = 1'b1;
        step(1);
        chk("btn_off", power, 0);
        power_btn = 1'b0;
        step(2);
        chk("btn_stay_off", power, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drive_arbiter.md
DRIVE_ARBITER -- requirements
Module: drive_arbiter

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 100000000, the power-button hold time in cycles needed for power-on.
REQ-002 SHALL provide parameter IDLE_CYCLES, default 1000000000, the cycles spent in NSTART before auto power-off.
REQ-003 SHALL have port clk  in  1  system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port power_btn  in  1  synchronized power-button level.
REQ-006 SHALL have port mode_sel  in  2  requested mode: 00 manual, 01 semi-auto, 10 auto, 11 reserved.
REQ-007 SHALL have port req_state  in  6  next_state requests packed {auto[5:4], semi[3:2], manual[1:0]}.
REQ-008 SHALL have port req_moving  in  12  next_moving_state requests packed {auto, semi, manual}, 4 bits each.
REQ-009 SHALL have port req_power  in  3  power-keep requests packed {auto, semi, manual}; 0 = request power-off.
REQ-010 SHALL have port power  out  1  vehicle power.
REQ-011 SHALL have port global_state  out  2  active mode.
REQ-012 SHALL have port state  out  2  car state: NSTART 00, START 01, MOVING 10.
REQ-013 SHALL have port moving_state  out  4  moving state: 0000 none, 0001 forward, 0010 back, 0100 left, 1000 right.
REQ-014 SHALL have port mode_reject  out  1  one-cycle pulse when a mode change is refused.

Function
REQ-015 SHALL implement power FSM states P_OFF, P_ARM, P_REL, P_ON; power = 1 exactly in P_REL and P_ON.
REQ-016 SHALL move P_OFF -> P_ARM when power_btn = 1, with the hold counter cleared.
REQ-017 SHALL, in P_ARM, increment the hold counter each cycle power_btn = 1.
REQ-018 SHALL, in P_ARM, return to P_OFF when power_btn = 0.
REQ-019 SHALL, in P_ARM, move to P_REL on the cycle the hold counter reaches HOLD_CYCLES-1 with power_btn = 1.
REQ-020 SHALL move P_REL -> P_ON when power_btn = 0, so the power-on hold is never read as power-off.
REQ-021 SHALL move P_ON -> P_OFF on any of: power_btn = 1; req_power bit of the active mode = 0; idle timeout.
REQ-022 SHALL register state and moving_state from the active mode's request lane, one-cycle latency, while power = 1.
REQ-023 SHALL force state = 00 and moving_state = 0000 while power = 0.
REQ-024 SHALL map a request of state 11 to NSTART with moving_state 0000.
REQ-025 SHALL load global_state from mode_sel only when power = 1, registered state = NSTART and mode_sel != 11; otherwise global_state holds.
REQ-026 SHALL judge mode acceptance against the registered state, so a mode change coinciding with leaving NSTART is accepted.
REQ-027 SHALL pulse mode_reject for exactly one cycle when mode_sel changes value while power = 1 and the change is refused; this requires a registered copy of mode_sel.
REQ-028 SHALL increment the idle counter only in P_ON with state = NSTART and power_btn = 0; any other condition clears it.
REQ-029 SHALL take the idle timeout on the cycle the idle counter reaches IDLE_CYCLES-1.
REQ-030 SHALL, on the cycle after any power-off, drive global_state = 00, state = 00, moving_state = 0000 and clear both counters.
REQ-031 SHALL treat simultaneous power-off causes as a single power-off.

Reset
REQ-032 SHALL, while rst = 0, immediately force the FSM to P_OFF and set power, global_state, state, moving_state, mode_reject, both counters and the mode_sel copy to 0.
REQ-033 SHALL, on reset assertion mid-hold or mid-drive, discard all progress; no partial power-on survives.

Structure
REQ-034 SHALL take the state, moving-state, mode and power encodings from shared package car_pkg.
REQ-035 SHALL instantiate sub-module hold_counter twice (hold and idle); ports: en, clr, terminal count parameter, done.

Verification (HOLD_CYCLES=4, IDLE_CYCLES=8)
REQ-036 SHALL cover: power_btn high 4 cycles then low -> power = 1 after the 4th cycle; P_ON reached only after release; a 3-cycle hold leaves power = 0.
REQ-037 SHALL cover: power on, manual lane requests state 01 then 10 with moving 0001 -> state/moving_state follow one cycle later; other lanes ignored.
REQ-038 SHALL cover: state = 10, mode_sel 00 -> 10 -> global_state stays 00 and mode_reject is 1 for one cycle; at state 00 the same change -> global_state = 10.
REQ-039 SHALL cover: power on, state = 00 held 8 cycles with power_btn low -> power = 0; all outputs 0 on the next cycle.
REQ-040 SHALL cover: active lane req_power = 0 while state = 10 -> power, state, moving_state = 0 next cycle; rst low mid-hold -> power stays 0.
